sliding_window_buffer: RTL and testbench
========================================

Name: sliding_window_buffer

Overview:
- Parametrised, registered WIN x WIN pixel window for the Sobel datapath. Sits between the pixel read path and the gradient engine.
- Holds the current neighbourhood and accepts pixels through a valid/ready handshake. Shifts left, right or down on request.
- Tracks which slots are empty with per-slot valid bits, so a pixel value of 0 is legal data.

Parameters:
PIXEL_W, 8, bits per pixel
WIN, 3, window edge length; odd, >= 3; window holds WIN*WIN slots

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
clear  input  1  synchronous flush of window and state
wr_valid  input  1  wr_data holds a pixel
wr_data  input  PIXEL_W  pixel to load
wr_ready  output  1  buffer can accept a pixel this cycle
shift_req  input  1  request a shift
shift_direc  input  2  01 left, 10 right, 11 down, 00 reserved
shift_done  output  1  one-cycle pulse, shift committed
window_flat  output  PIXEL_W*WIN*WIN  slot k at bits [k*PIXEL_W +: PIXEL_W]
window_valid  output  1  all slots valid
fill_count  output  $clog2(WIN*WIN+1)  number of valid slots

Behaviour:
- Slot layout: column-major, slot k = c*WIN + r, where c is the column (0..WIN-1) and r is the row within the column.
- Reset (n_rst low, async): all slot data 0, all valid bits 0, fill_count 0, state FILLING, wr_ready 1, window_valid 0, shift_done 0.
- clear=1 at a rising edge: same reset state on the next cycle. clear has priority over writes and shifts.
- FSM states: FILLING, READY.
- FILLING:
  - wr_ready=1.
  - On wr_valid & wr_ready, the pixel is written to the lowest-index slot whose valid bit is 0; that valid bit is set and fill_count increments. The new pixel is visible on window_flat one cycle later.
  - When the write makes fill_count = WIN*WIN, the state moves to READY in the same update.
  - shift_req is ignored in FILLING.
- READY:
  - window_valid=1, wr_ready=0; wr_valid is ignored.
  - shift_req=1 with a legal direction commits the shift at the next edge.
  - After the shift: shift_done=1 for exactly that one cycle, the vacated WIN slots have data 0 and valid 0, fill_count = WIN*WIN-WIN, state FILLING.
  - shift_direc=00: request ignored, no shift_done, state stays READY.
- Shift left: column c takes column c+1 for c < WIN-1; column WIN-1 is vacated.
- Shift right: column c takes column c-1 for c > 0; column 0 is vacated.
- Shift down: within every column, row r takes row r-1 for r > 0; row 0 of every column is vacated.
- Back-to-back operation: writes may start in the cycle shift_done is high, since wr_ready=1 that cycle. Shift latency is 1 cycle; write latency is 1 cycle.
- Reset asserted mid-fill or mid-shift wins immediately. No partial shift survives reset.
- All outputs are registered or decoded only from registered state. No combinational path from wr_valid or shift_req to any output.

Optional Feature:
- Macro: SWB_EDGE_REPLICATE_EN.
- Defined: adds input port pad_edge (1 bit).
  - A shift accepted with pad_edge=1 fills the vacated slots with copies of the adjacent surviving line instead of 0. Left copies new column WIN-2 into WIN-1; right copies column 1 into 0; down copies row 1 into row 0.
  - Replicated slots stay valid, fill_count stays WIN*WIN, state stays READY, and shift_done still pulses.
  - pad_edge=0 gives the standard behaviour.
- Undefined: port absent; vacated slots are always zeroed and refilled.

Test Plan:
- Reset, then write 1..9 on consecutive cycles (WIN=3) -> wr_ready falls and window_valid rises the cycle after the 9th write. window_flat = 1..9 in slots 0..8, fill_count=9.
- From the full window 1..9, shift left (01) -> next cycle shift_done=1, slots 0..5 = 4..9, slots 6..8 = 0 invalid, fill_count=6. Write 10,11,12 -> slots 6,7,8 = 10,11,12, window_valid=1.
- From the full window 1..9, shift down (11) -> slots = 0,1,2,0,4,5,0,7,8 with slots 0,3,6 invalid. Write 0,0,0 -> fill_count=9, window_valid=1, which proves zero pixels count as valid data.
- shift_req during FILLING, and shift_direc=00 in READY -> window unchanged, no shift_done. wr_valid in READY -> no write, fill_count stays 9.
- After 5 writes, assert n_rst low mid-cycle -> outputs go to reset values immediately. After 5 writes, pulse clear -> reset state next cycle, fill_count=0.
- With SWB_EDGE_REPLICATE_EN and the full window 1..9, shift right with pad_edge=1 -> slots = 1,2,3,1,2,3,4,5,6, window_valid stays 1, shift_done pulses once.

Source files
------------

// File: rtl/sliding_window_buffer_if.sv
// rtl/sliding_window_buffer_if.sv - pixel write and shift handshake bundle for the Sobel window buffer.
// The master side drives pixels and shift requests; the slave side is the window buffer.
interface sliding_window_buffer_if #(
  parameter int PIXEL_W = 8,
  parameter int WIN     = 3
);
  localparam int CNT_W = $clog2(WIN*WIN+1);

  logic                       wr_valid;
  logic [PIXEL_W-1:0]         wr_data;
  logic                       wr_ready;
  logic                       shift_req;
  logic [1:0]                 shift_direc;
  logic                       shift_done;
  logic [PIXEL_W*WIN*WIN-1:0] window_flat;
  logic                       window_valid;
  logic [CNT_W-1:0]           fill_count;

  modport master (
    output wr_valid, wr_data, shift_req, shift_direc,
    input  wr_ready, shift_done, window_flat, window_valid, fill_count
  );

  modport slave (
    input  wr_valid, wr_data, shift_req, shift_direc,
    output wr_ready, shift_done, window_flat, window_valid, fill_count
  );
endinterface

// File: rtl/sliding_window_buffer.sv
// rtl/sliding_window_buffer.sv - registered WIN x WIN pixel window with fill tracking and left/right/down shifts.
// Optional edge replication on shift is enabled by defining SWB_EDGE_REPLICATE_EN (adds pad_edge).
module sliding_window_buffer #(
  parameter int PIXEL_W = 8,
  parameter int WIN     = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
`ifdef SWB_EDGE_REPLICATE_EN
  input  logic pad_edge,
`endif
  sliding_window_buffer_if.slave bus
);
  localparam int SLOTS = WIN*WIN;
  localparam int IDX_W = $clog2(SLOTS);
  localparam int CNT_W = $clog2(SLOTS+1);

  typedef enum logic {FILLING = 1'b0, READY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PIXEL_W-1:0] data_q [SLOTS];
  logic [PIXEL_W-1:0] data_d [SLOTS];
  logic [SLOTS-1:0]   valid_q, valid_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;

  logic               pad;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic               shift_go;
  logic               vac;
  int                 src;

`ifdef SWB_EDGE_REPLICATE_EN
  assign pad = pad_edge;
`else
  assign pad = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= FILLING;
      valid_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < SLOTS; k++) data_q[k] <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      count_q <= count_d;
      done_q  <= done_d;
      for (int k = 0; k < SLOTS; k++) data_q[k] <= data_d[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    count_d    = count_q;
    done_d     = 1'b0;
    for (int k = 0; k < SLOTS; k++) data_d[k] = data_q[k];
    free_found = 1'b0;
    free_idx   = '0;
    vac        = 1'b0;
    src        = 0;
    shift_go   = (state_q == READY) && bus.shift_req && (bus.shift_direc != 2'b00);

    // Descending scan leaves the lowest empty slot as the write target.
    for (int k = SLOTS-1; k >= 0; k--) begin
      if (!valid_q[k]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(k);
      end
    end

    if (clear) begin
      state_d = FILLING;
      valid_d = '0;
      count_d = '0;
      for (int k = 0; k < SLOTS; k++) data_d[k] = '0;
    end else if (state_q == FILLING) begin
      if (bus.wr_valid && free_found) begin
        data_d[free_idx]  = bus.wr_data;
        valid_d[free_idx] = 1'b1;
        count_d           = count_q + CNT_W'(1);
        if (count_q == CNT_W'(SLOTS-1)) state_d = READY;
      end
    end else if (shift_go) begin
      done_d = 1'b1;
      for (int c = 0; c < WIN; c++) begin
        for (int r = 0; r < WIN; r++) begin
          // A vacated slot's replica source is the line that used to sit there.
          case (bus.shift_direc)
            2'b01: begin vac = (c == WIN-1); src = vac ? c*WIN+r : (c+1)*WIN+r; end
            2'b10: begin vac = (c == 0);     src = vac ? c*WIN+r : (c-1)*WIN+r; end
            2'b11: begin vac = (r == 0);     src = vac ? c*WIN+r : c*WIN+r-1;   end
            default: begin vac = 1'b0;       src = c*WIN+r;                      end
          endcase
          if (vac && !pad) begin
            data_d[IDX_W'(c*WIN+r)]  = '0;
            valid_d[IDX_W'(c*WIN+r)] = 1'b0;
          end else begin
            data_d[IDX_W'(c*WIN+r)]  = data_q[IDX_W'(src)];
            valid_d[IDX_W'(c*WIN+r)] = valid_q[IDX_W'(src)];
          end
        end
      end
      count_d = pad ? CNT_W'(SLOTS) : CNT_W'(SLOTS-WIN);
      state_d = pad ? READY : FILLING;
    end
  end

  genvar g;
  generate
    for (g = 0; g < SLOTS; g++) begin : g_flat
      assign bus.window_flat[g*PIXEL_W +: PIXEL_W] = data_q[g];
    end
  endgenerate

  assign bus.wr_ready     = (state_q == FILLING);
  assign bus.window_valid = (state_q == READY);
  assign bus.fill_count   = count_q;
  assign bus.shift_done   = done_q;
endmodule

// File: tb/tb_sliding_window_buffer.sv
// tb/tb_sliding_window_buffer.sv - directed self-checking bench for sliding_window_buffer (WIN=3, PIXEL_W=8).
module tb_sliding_window_buffer;
  logic clk;
  logic n_rst;
  logic clear;
`ifdef SWB_EDGE_REPLICATE_EN
  logic pad_edge;
`endif
  int n_tests;
  int n_fail;

  sliding_window_buffer_if #(.PIXEL_W(8), .WIN(3)) bus ();

  sliding_window_buffer #(.PIXEL_W(8), .WIN(3)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .clear (clear),
`ifdef SWB_EDGE_REPLICATE_EN
    .pad_edge (pad_edge),
`endif
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] w9(input logic [7:0] s0, s1, s2, s3, s4, s5, s6, s7, s8);
    return {s8, s7, s6, s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input logic [7:0] v);
    bus.wr_valid = 1'b1;
    bus.wr_data  = v;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  task automatic shift(input logic [1:0] dir);
    bus.shift_req   = 1'b1;
    bus.shift_direc = dir;
    tick();
    bus.shift_req   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill_1_to_9();
    for (int i = 1; i <= 9; i++) write_px(8'(i));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clear = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data = '0;
    bus.shift_req = 1'b0;
    bus.shift_direc = 2'b00;
`ifdef SWB_EDGE_REPLICATE_EN
    pad_edge = 1'b0;
`endif
    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    #2;
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_window_valid", bus.window_valid, 0);
    check("rst_fill", bus.fill_count, 0);
    check("rst_done", bus.shift_done, 0);
    check("rst_flat", bus.window_flat, 0);
    #8 n_rst = 1'b1;

    for (int i = 1; i <= 8; i++) write_px(8'(i));
    check("fill8_count", bus.fill_count, 8);
    check("fill8_not_valid", bus.window_valid, 0);
    check("fill8_ready", bus.wr_ready, 1);
    write_px(8'd9);
    check("fill9_count", bus.fill_count, 9);
    check("fill9_valid", bus.window_valid, 1);
    check("fill9_ready", bus.wr_ready, 0);
    check("fill9_flat", bus.window_flat, w9(1, 2, 3, 4, 5, 6, 7, 8, 9));

    shift(2'b01);
    check("left_done", bus.shift_done, 1);
    check("left_flat", bus.window_flat, w9(4, 5, 6, 7, 8, 9, 0, 0, 0));
    check("left_fill", bus.fill_count, 6);
    check("left_ready", bus.wr_ready, 1);
    check("left_not_valid", bus.window_valid, 0);
    write_px(8'd10);
    check("left_done_once", bus.shift_done, 0);
    write_px(8'd11);
    write_px(8'd12);
    check("left_refill_flat", bus.window_flat, w9(4, 5, 6, 7, 8, 9, 10, 11, 12));
    check("left_refill_valid", bus.window_valid, 1);

    do_clear();
    check("clear_fill", bus.fill_count, 0);
    check("clear_flat", bus.window_flat, 0);
    fill_1_to_9();
    shift(2'b11);
    check("down_flat", bus.window_flat, w9(0, 1, 2, 0, 4, 5, 0, 7, 8));
    check("down_fill", bus.fill_count, 6);
    write_px(8'd0);
    write_px(8'd0);
    check("down_partial_fill", bus.fill_count, 8);
    write_px(8'd0);
    check("down_zero_fill", bus.fill_count, 9);
    check("down_zero_valid", bus.window_valid, 1);
    check("down_zero_flat", bus.window_flat, w9(0, 1, 2, 0, 4, 5, 0, 7, 8));

    do_clear();
    fill_1_to_9();
    shift(2'b00);
    check("dir00_done", bus.shift_done, 0);
    check("dir00_valid", bus.window_valid, 1);
    check("dir00_flat", bus.window_flat, w9(1, 2, 3, 4, 5, 6, 7, 8, 9));
    write_px(8'd55);
    check("ready_wr_fill", bus.fill_count, 9);
    check("ready_wr_flat", bus.window_flat, w9(1, 2, 3, 4, 5, 6, 7, 8, 9));

    shift(2'b10);
    check("right_done", bus.shift_done, 1);
    check("right_flat", bus.window_flat, w9(0, 0, 0, 1, 2, 3, 4, 5, 6));
    check("right_fill", bus.fill_count, 6);
    tick();
    shift(2'b01);
    check("fill_shift_done", bus.shift_done, 0);
    check("fill_shift_flat", bus.window_flat, w9(0, 0, 0, 1, 2, 3, 4, 5, 6));
    check("fill_shift_count", bus.fill_count, 6);
    write_px(8'd20);
    check("right_refill_slot0", bus.window_flat, w9(20, 0, 0, 1, 2, 3, 4, 5, 6));

    do_clear();
    for (int i = 1; i <= 5; i++) write_px(8'(i));
    check("mid5_fill", bus.fill_count, 5);
    #3 n_rst = 1'b0;
    #1;
    check("async_rst_fill", bus.fill_count, 0);
    check("async_rst_flat", bus.window_flat, 0);
    check("async_rst_ready", bus.wr_ready, 1);
    n_rst = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) write_px(8'(i));
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'd77;
    do_clear();
    bus.wr_valid = 1'b0;
    check("clear_prio_fill", bus.fill_count, 0);
    check("clear_prio_flat", bus.window_flat, 0);

`ifdef SWB_EDGE_REPLICATE_EN
    fill_1_to_9();
    pad_edge = 1'b1;
    shift(2'b10);
    pad_edge = 1'b0;
    check("pad_right_flat", bus.window_flat, w9(1, 2, 3, 1, 2, 3, 4, 5, 6));
    check("pad_right_done", bus.shift_done, 1);
    check("pad_right_valid", bus.window_valid, 1);
    check("pad_right_fill", bus.fill_count, 9);
    tick();
    check("pad_right_done_once", bus.shift_done, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
